// File: rtl/btn_press_decoder.sv
// btn_press_decoder: classifies debounced button gestures into short, long/repeat and double-click pulses.
module btn_press_decoder #(
    parameter int CNT_W      = 16,
    parameter int LONG_TICKS = 1000,
    parameter int DBL_GAP    = 300,
    parameter int RPT_TICKS  = 200
) (
    input  logic       clk_i,
    input  logic       rst_1,
    input  logic       sw_state_i,
    input  logic       sw_down_i,
    input  logic       sw_up_i,
    output logic       short_o,
    output logic       long_o,
    output logic       repeat_o,
    output logic       double_o,
    output logic       busy_o,
    output logic [7:0] press_cnt_o
);
    typedef enum logic [2:0] {IDLE, PRESS1, LONG_HOLD, WAIT2, PRESS2} state_t;

    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_END  = CNT_W'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] RPT_END  = CNT_W'(RPT_TICKS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             short_nxt, long_nxt, repeat_nxt, double_nxt;
    logic             dn, rel;

    // simultaneous down/up edges are illegal and dropped; a low level still counts as release
    assign dn  = sw_down_i & ~sw_up_i;
    assign rel = (sw_up_i & ~sw_down_i) | ~sw_state_i;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 1'b1;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (dn) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (rel) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_END) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HOLD;
                    cnt_nxt   = '0;
                end
            end
            LONG_HOLD: begin
                if (rel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == RPT_END) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end
            end
            WAIT2: begin
                if (dn) begin
                    state_nxt = PRESS2;
                    cnt_nxt   = '0;
                end else if (cnt == DBL_END) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            PRESS2: begin
                if (rel) begin
                    double_nxt = 1'b1;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end else if (cnt == LONG_END) begin
                    short_nxt = 1'b1;
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HOLD;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_1) begin
        if (rst_1) begin
            state       <= IDLE;
            cnt         <= '0;
            short_o     <= 1'b0;
            long_o      <= 1'b0;
            repeat_o    <= 1'b0;
            double_o    <= 1'b0;
            busy_o      <= 1'b0;
            press_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            short_o     <= short_nxt;
            long_o      <= long_nxt;
            repeat_o    <= repeat_nxt;
            double_o    <= double_nxt;
            busy_o      <= state_nxt != IDLE;
            press_cnt_o <= press_cnt_o + 8'(dn);
        end
    end
endmodule

// File: doc/btn_press_decoder.md
Name: btn_press_decoder

Overview:
- Sits directly downstream of the switch debouncer and consumes its sw_state / sw_down / sw_up outputs.
- Classifies each debounced button gesture as short press, long press (with auto-repeat while held) or double click.
- Emits one-clock event pulses and keeps a running press counter for the control logic above it.

Parameters:
- CNT_W, 16, width of the internal timing counter.
- LONG_TICKS, 1000, cycles a press must be held to count as a long press (2..2^CNT_W-1).
- DBL_GAP, 300, maximum release-to-second-press gap in cycles for a double click (2..2^CNT_W-1).
- RPT_TICKS, 200, auto-repeat period in cycles while a long press is held (2..2^CNT_W-1).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_1  in  1  reset, asynchronous, active-high
- sw_state_i  in  1  debounced switch level, 1 = pressed
- sw_down_i  in  1  one-cycle press-edge pulse from the debouncer
- sw_up_i  in  1  one-cycle release-edge pulse from the debouncer
- short_o  out  1  one-cycle pulse: single short press recognised
- long_o  out  1  one-cycle pulse: hold reached LONG_TICKS
- repeat_o  out  1  one-cycle pulse every RPT_TICKS while a long press is held
- double_o  out  1  one-cycle pulse: double click recognised
- busy_o  out  1  1 while a gesture is in progress (state != IDLE)
- press_cnt_o  out  8  count of accepted sw_down_i events, wraps 255->0

Behaviour:
- Reset: state=IDLE; cnt=0; press_cnt_o=0; short_o, long_o, repeat_o, double_o and busy_o all 0. Asserting rst_1 mid-gesture aborts the gesture immediately and no pulse is emitted.
- All outputs are registered. An event pulse is high for exactly the one cycle after the edge at which its condition is evaluated. At most one of short_o/long_o/repeat_o/double_o is high per cycle, except the PRESS2 long case below.
- Release condition "rel" = sw_up_i=1 OR sw_state_i=0. This guards against a missed sw_up pulse.
- sw_down_i and sw_up_i high in the same cycle is illegal. Both are ignored, and press_cnt_o is not incremented.
- press_cnt_o increments on every accepted sw_down_i, in any state.
- FSM (cnt counts clock cycles in the current state, cleared on each state entry):
  - IDLE: on sw_down_i -> PRESS1. sw_up_i is ignored.
  - PRESS1:
    - rel -> WAIT2.
    - Else if cnt==LONG_TICKS-1 -> long_o pulse, go to LONG_HOLD.
    - Else cnt++.
  - LONG_HOLD:
    - rel -> IDLE, no pulse.
    - Else if cnt==RPT_TICKS-1 -> repeat_o pulse, cnt=0.
    - Else cnt++.
    - The first repeat_o comes RPT_TICKS cycles after long_o.
  - WAIT2:
    - sw_down_i -> PRESS2.
    - Else if cnt==DBL_GAP-1 -> short_o pulse, go to IDLE.
    - Else cnt++.
  - PRESS2:
    - rel -> double_o pulse, go to IDLE.
    - Else if cnt==LONG_TICKS-1 -> short_o and long_o pulse together (first press was short, second is long), go to LONG_HOLD.
    - Else cnt++.
- Latencies:
  - short_o rises DBL_GAP cycles after the edge that sampled sw_up_i.
  - long_o rises LONG_TICKS cycles after the edge that sampled sw_down_i.
  - double_o rises 1 cycle after the edge that sampled the second release.
- Boundaries:
  - A release at exactly cnt==LONG_TICKS-1 in PRESS1 takes priority: the gesture is short, not long.
  - A second sw_down_i at exactly cnt==DBL_GAP-1 in WAIT2 takes priority: the gesture is a double click.
  - A third press after double_o starts a new gesture from IDLE.
- cnt never exceeds max(LONG_TICKS, DBL_GAP, RPT_TICKS)-1, so it has no wrap in normal operation.

Test Plan (LONG_TICKS=20, DBL_GAP=10, RPT_TICKS=5):
- Reset mid-PRESS1: sw_down at t0, rst_1 pulse 4 ns at t0+5 cycles -> all outputs 0, busy_o=0, press_cnt_o=0, no pulse for 30 cycles.
- Short press: sw_down, release after 8 cycles -> exactly one short_o, 10 cycles after the sw_up edge; press_cnt_o=1; busy_o falls with it.
- Long press with repeat: hold 40 cycles -> long_o at +20 cycles; repeat_o at +25, +30, +35 and +40 only if still held; release -> IDLE with no short_o.
- Double click: press 3, release, gap 4, press 3, release -> one double_o 1 cycle after the second release; no short_o; press_cnt_o=2.
- Boundaries: release exactly at cycle 19 -> short_o, no long_o; second press at gap cycle 9 -> double_o; gap 11 -> short_o, then a new gesture starts.
- Illegal and wrap cases: simultaneous sw_down/sw_up is ignored; 256 short presses -> press_cnt_o wraps to 0.
